// File: rtl/ps_frame_buffer.sv
// Ping-pong power-spectrum frame buffer between the FFT/power stage and the mel filterbank.
// Two banks alternate: one fills from upstream while the other is held for the mel stage to read.
module ps_frame_buffer #(
  parameter int NFFT   = 257,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ps_valid_i,
  input  logic [DATA_W-1:0]        ps_data_i,
  input  logic                     ps_last_i,
  output logic                     ps_ready_o,
  output logic                     mel_start_o,
  input  logic [$clog2(NFFT):0]    prt_power_spectrum_frame,
  output logic [DATA_W-1:0]        value_power_spectrum_frame,
  input  logic                     mel_done_i,
  output logic                     mel_busy_o,
  output logic                     frame_err_o
);
  // state    | meaning
  // RD_IDLE  | no bank handed to the mel stage; waiting for rd_bank to be FULL
  // RD_BUSY  | rd_bank is READING; waiting for mel_done_i
  localparam int CNT_W = $clog2(NFFT);
  localparam int IDX_W = $clog2(NFFT) + 1;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_READING = 2'd3;

  localparam logic RD_IDLE = 1'b0;
  localparam logic RD_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NFFT - 1);

  logic [DATA_W-1:0] mem_a [NFFT];
  logic [DATA_W-1:0] mem_b [NFFT];

  logic [1:0][1:0]   bank_q, bank_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              rd_state_q, rd_state_d;
  logic              mel_start_q, mel_start_d;
  logic              frame_err_q, frame_err_d;

  logic [1:0] wr_st;
  logic       hs;
  logic       at_last;
  logic       wr_en;

  assign wr_st      = bank_q[wr_bank_q];
  assign ps_ready_o = (wr_st == ST_EMPTY) || (wr_st == ST_FILLING);
  assign hs         = ps_valid_i & ps_ready_o;
  assign at_last    = (wr_cnt_q == LAST_CNT);
  // An early last marker aborts the frame, so that word is never stored.
  assign wr_en      = hs & (at_last | ~ps_last_i);

  always_comb begin
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_state_d  = rd_state_q;
    mel_start_d = 1'b0;
    frame_err_d = 1'b0;

    if (hs) begin
      if (at_last) begin
        bank_d[wr_bank_q] = ST_FULL;
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
        frame_err_d       = ~ps_last_i;
      end else if (ps_last_i) begin
        bank_d[wr_bank_q] = ST_EMPTY;
        wr_cnt_d          = '0;
        frame_err_d       = 1'b1;
      end else begin
        bank_d[wr_bank_q] = ST_FILLING;
        wr_cnt_d          = wr_cnt_q + CNT_W'(1);
      end
    end

    // Read side only touches rd_bank, which is never the bank being filled while FULL/READING.
    case (rd_state_q)
      RD_IDLE: begin
        if (bank_q[rd_bank_q] == ST_FULL) begin
          bank_d[rd_bank_q] = ST_READING;
          mel_start_d       = 1'b1;
          rd_state_d        = RD_BUSY;
        end
      end
      default: begin
        if (mel_done_i) begin
          bank_d[rd_bank_q] = ST_EMPTY;
          rd_bank_d         = ~rd_bank_q;
          rd_state_d        = RD_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_state_q  <= RD_IDLE;
      mel_start_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_state_q  <= rd_state_d;
      mel_start_q <= mel_start_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank_q) mem_a[wr_cnt_q] <= ps_data_i;
    if (wr_en && wr_bank_q)  mem_b[wr_cnt_q] <= ps_data_i;
  end

  always_comb begin
    value_power_spectrum_frame = '0;
    if (prt_power_spectrum_frame < IDX_W'(NFFT)) begin
      if (rd_bank_q) value_power_spectrum_frame = mem_b[prt_power_spectrum_frame[CNT_W-1:0]];
      else           value_power_spectrum_frame = mem_a[prt_power_spectrum_frame[CNT_W-1:0]];
    end
  end

  assign mel_start_o = mel_start_q;
  assign frame_err_o = frame_err_q;
  assign mel_busy_o  = (rd_state_q == RD_BUSY);

endmodule

// File: tb/tb_ps_frame_buffer.sv
// Scoreboard bench for ps_frame_buffer: frame seeds are queued when a good frame is written
// and popped when the buffer hands a frame to the mel side.
module tb_ps_frame_buffer;
  localparam int NFFT   = 257;
  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(NFFT) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ps_valid_i;
  logic [DATA_W-1:0] ps_data_i;
  logic              ps_last_i;
  logic              ps_ready_o;
  logic              mel_start_o;
  logic [IDX_W-1:0]  prt;
  logic [DATA_W-1:0] value;
  logic              mel_done_i;
  logic              mel_busy_o;
  logic              frame_err_o;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int s0;
  int unsigned exp_q[$];

  ps_frame_buffer #(.NFFT(NFFT), .DATA_W(DATA_W)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .ps_valid_i                 (ps_valid_i),
    .ps_data_i                  (ps_data_i),
    .ps_last_i                  (ps_last_i),
    .ps_ready_o                 (ps_ready_o),
    .mel_start_o                (mel_start_o),
    .prt_power_spectrum_frame   (prt),
    .value_power_spectrum_frame (value),
    .mel_done_i                 (mel_done_i),
    .mel_busy_o                 (mel_busy_o),
    .frame_err_o                (frame_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mel_start_o) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int unsigned seed, input int n, input int last_at, input bit done_last);
    bit blocked = 1'b0;
    for (int i = 0; i < n; i++) begin
      ps_valid_i = 1'b1;
      ps_data_i  = 32'(seed + 32'(i) * 3);
      ps_last_i  = (i == last_at);
      mel_done_i = done_last && (i == n - 1);
      if (!ps_ready_o) blocked = 1'b1;
      tick();
    end
    ps_valid_i = 1'b0;
    ps_last_i  = 1'b0;
    mel_done_i = 1'b0;
    chk("ready_in_frame", 32'(blocked), 32'd0);
  endtask

  task automatic expect_start();
    int n = 0;
    while (!mel_start_o && n < 20) begin
      tick();
      n++;
    end
    chk("start_latency", 32'(n), 32'd1);
  endtask

  task automatic check_frame();
    int idxs[4] = '{0, 1, 100, 256};
    int unsigned s;
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      s = exp_q.pop_front();
      chk("busy_reading", 32'(mel_busy_o), 32'd1);
      foreach (idxs[k]) begin
        prt = IDX_W'(idxs[k]);
        #1;
        chk("rd_data", value, 32'(s + 32'(idxs[k]) * 3));
      end
      prt = IDX_W'(300);
      #1;
      chk("rd_oob_300", value, 32'd0);
      prt = IDX_W'(257);
      #1;
      chk("rd_oob_257", value, 32'd0);
    end
  endtask

  task automatic done_pulse();
    mel_done_i = 1'b1;
    tick();
    mel_done_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    ps_valid_i = 1'b0;
    ps_data_i  = '0;
    ps_last_i  = 1'b0;
    mel_done_i = 1'b0;
    prt        = '0;
    #22;
    chk("rst_ready", 32'(ps_ready_o), 32'd1);
    chk("rst_start", 32'(mel_start_o), 32'd0);
    chk("rst_busy", 32'(mel_busy_o), 32'd0);
    chk("rst_err", 32'(frame_err_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // basic frame: index*3
    s0 = start_cnt;
    exp_q.push_back(0);
    send_frame(0, 257, 256, 1'b0);
    chk("err_quiet", 32'(frame_err_o), 32'd0);
    expect_start();
    check_frame();
    tick();
    tick();
    chk("start_single", 32'(start_cnt - s0), 32'd1);
    done_pulse();
    chk("busy_released", 32'(mel_busy_o), 32'd0);

    // mel_done while idle is ignored
    s0 = start_cnt;
    done_pulse();
    tick();
    chk("idle_done_busy", 32'(mel_busy_o), 32'd0);
    chk("idle_done_ready", 32'(ps_ready_o), 32'd1);
    chk("idle_done_start", 32'(start_cnt - s0), 32'd0);

    // early last marker aborts the frame
    s0 = start_cnt;
    send_frame(500, 11, 10, 1'b0);
    chk("err_pulse", 32'(frame_err_o), 32'd1);
    tick();
    chk("err_clear", 32'(frame_err_o), 32'd0);
    repeat (3) tick();
    chk("err_no_start", 32'(start_cnt - s0), 32'd0);
    exp_q.push_back(1000);
    send_frame(1000, 257, 256, 1'b0);
    expect_start();
    check_frame();
    done_pulse();

    // three frames back to back
    exp_q.push_back(2000);
    exp_q.push_back(3000);
    send_frame(2000, 257, 256, 1'b0);
    send_frame(3000, 257, 256, 1'b0);
    chk("ready_blocked", 32'(ps_ready_o), 32'd0);
    ps_valid_i = 1'b1;
    ps_data_i  = 32'd4000;
    tick();
    chk("ready_still_blocked", 32'(ps_ready_o), 32'd0);
    ps_valid_i = 1'b0;
    check_frame();
    done_pulse();
    chk("ready_after_done", 32'(ps_ready_o), 32'd1);
    expect_start();
    check_frame();
    exp_q.push_back(4000);
    send_frame(4000, 257, 256, 1'b0);
    done_pulse();
    expect_start();
    check_frame();
    done_pulse();

    // mel_done on the same edge a frame completes
    exp_q.push_back(5000);
    send_frame(5000, 257, 256, 1'b0);
    expect_start();
    check_frame();
    exp_q.push_back(6000);
    send_frame(6000, 257, 256, 1'b1);
    chk("coinc_busy", 32'(mel_busy_o), 32'd0);
    expect_start();
    check_frame();
    done_pulse();

    // async reset mid-read
    exp_q.push_back(7000);
    send_frame(7000, 257, 256, 1'b0);
    expect_start();
    check_frame();
    prt = IDX_W'(50);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ps_ready_o), 32'd1);
    chk("arst_busy", 32'(mel_busy_o), 32'd0);
    chk("arst_start", 32'(mel_start_o), 32'd0);
    chk("arst_err", 32'(frame_err_o), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();
    exp_q.push_back(8000);
    send_frame(8000, 257, 256, 1'b0);
    expect_start();
    check_frame();
    done_pulse();

    // final word without last marker: completes but flags an error
    exp_q.push_back(9000);
    send_frame(9000, 257, 999, 1'b0);
    chk("err_no_last", 32'(frame_err_o), 32'd1);
    expect_start();
    check_frame();
    done_pulse();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
